// File: rtl/ternary_stream_loader.sv
// Stream-fed instruction memory loader with LOAD and VERIFY modes over a balanced-ternary address space.
// Trit encoding: 2'b00 = 0, 2'b01 = +1, 2'b10 = -1, 2'b11 = undefined.
module ternary_stream_loader #(
  parameter int WORD_TRITS = 9,
  parameter int ADDR_TRITS = 4,
  parameter int CNT_W      = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    verify_mode,
  input  logic [2*ADDR_TRITS-1:0] base_addr,
  input  logic [CNT_W-1:0]        word_count,
  input  logic                    in_valid,
  input  logic [2*WORD_TRITS-1:0] in_data,
  output logic                    in_ready,
  output logic [2*ADDR_TRITS-1:0] mem_addr,
  output logic [2*WORD_TRITS-1:0] mem_write_data,
  output logic                    mem_write,
  output logic                    mem_read,
  input  logic [2*WORD_TRITS-1:0] mem_read_data,
  output logic                    busy,
  output logic                    load_complete,
  output logic                    error,
  output logic [1:0]              error_code,
  output logic [CNT_W-1:0]        words_done
);

  localparam logic [1:0] T_ZERO = 2'b00;
  localparam logic [1:0] T_POS  = 2'b01;
  localparam logic [1:0] T_NEG  = 2'b10;
  localparam logic [1:0] T_BAD  = 2'b11;
  localparam logic [2*ADDR_TRITS-1:0] MAX_ADDR = {ADDR_TRITS{T_POS}};

  localparam logic [1:0] EC_OVERFLOW = 2'b01;
  localparam logic [1:0] EC_DATA     = 2'b10;
  localparam logic [1:0] EC_ABORT    = 2'b11;

  typedef enum logic [2:0] {
    IDLE, ACCEPT, WRITE, READ, COMPARE, DONE, ERROR
  } state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  state_t                  w_advState;
  logic                    r_verify;
  logic [CNT_W-1:0]        r_wordCount;
  logic [CNT_W-1:0]        r_wordsDone;
  logic [2*ADDR_TRITS-1:0] r_memAddr;
  logic [2*WORD_TRITS-1:0] r_writeData;
  logic [1:0]              r_errorCode;
  logic [CNT_W-1:0]        w_newDone;
  logic                    w_lastWord;
  logic                    w_atMax;
  logic                    w_badTrit;
  logic                    w_mismatch;

  function automatic logic hasBadTrit(input logic [2*WORD_TRITS-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < WORD_TRITS; i++) begin
      if (w[2*i +: 2] == T_BAD) bad = 1'b1;
    end
    return bad;
  endfunction

  // Balanced-ternary +1: a +1 trit rolls over to -1 and carries into the next trit.
  function automatic logic [2*ADDR_TRITS-1:0] ternaryInc(input logic [2*ADDR_TRITS-1:0] a);
    logic [2*ADDR_TRITS-1:0] r;
    logic                    carry;
    r     = a;
    carry = 1'b1;
    for (int i = 0; i < ADDR_TRITS; i++) begin
      if (carry) begin
        case (a[2*i +: 2])
          T_ZERO:  begin r[2*i +: 2] = T_POS;  carry = 1'b0; end
          T_NEG:   begin r[2*i +: 2] = T_ZERO; carry = 1'b0; end
          default: r[2*i +: 2] = T_NEG;
        endcase
      end
    end
    return r;
  endfunction

  assign w_newDone  = r_wordsDone + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_lastWord = (w_newDone == r_wordCount);
  assign w_atMax    = (r_memAddr == MAX_ADDR);
  assign w_badTrit  = hasBadTrit(in_data);
  assign w_mismatch = (mem_read_data != r_writeData);
  assign w_advState = w_lastWord ? DONE : (w_atMax ? ERROR : ACCEPT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Strobes and in_ready are gated by abort so an aborted cycle has no side effects.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE, DONE, ERROR: begin
        if (start) w_nextState = (word_count == '0) ? DONE : ACCEPT;
      end
      ACCEPT: begin
        busy     = 1'b1;
        in_ready = !abort;
        if (abort)         w_nextState = ERROR;
        else if (in_valid) w_nextState = w_badTrit ? ERROR : (r_verify ? READ : WRITE);
      end
      WRITE: begin
        busy        = 1'b1;
        mem_write   = !abort;
        w_nextState = abort ? ERROR : w_advState;
      end
      READ: begin
        busy        = 1'b1;
        mem_read    = !abort;
        w_nextState = abort ? ERROR : COMPARE;
      end
      COMPARE: begin
        busy = 1'b1;
        if (abort || w_mismatch) w_nextState = ERROR;
        else                     w_nextState = w_advState;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_verify    <= 1'b0;
      r_wordCount <= '0;
      r_wordsDone <= '0;
      r_memAddr   <= '0;
      r_writeData <= '0;
      r_errorCode <= '0;
    end else begin
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            r_verify    <= verify_mode;
            r_wordCount <= word_count;
            r_memAddr   <= base_addr;
            r_wordsDone <= '0;
            r_errorCode <= '0;
          end
        end
        ACCEPT: begin
          if (abort) begin
            r_errorCode <= EC_ABORT;
          end else if (in_valid) begin
            r_writeData <= in_data;
            if (w_badTrit) r_errorCode <= EC_DATA;
          end
        end
        WRITE, COMPARE: begin
          if (abort) begin
            r_errorCode <= EC_ABORT;
          end else if (r_state == COMPARE && w_mismatch) begin
            r_errorCode <= EC_DATA;
          end else begin
            r_wordsDone <= w_newDone;
            if (!w_lastWord) begin
              if (w_atMax) r_errorCode <= EC_OVERFLOW;
              else         r_memAddr   <= ternaryInc(r_memAddr);
            end
          end
        end
        READ: begin
          if (abort) r_errorCode <= EC_ABORT;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr       = r_memAddr;
  assign mem_write_data = r_writeData;
  assign words_done     = r_wordsDone;
  assign error_code     = r_errorCode;
  assign load_complete  = (r_state == DONE);
  assign error          = (r_state == ERROR);

endmodule
